// File: rtl/v2f_sched_pkg.sv
// Shared definitions for the v2f ALU scheduler: opcode encoding and the
// round-robin search used by the arbiter.
package v2f_sched_pkg;

  localparam int OPW  = 4;
  localparam int MAXN = 16;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_MUL = 4'd2;
  localparam logic [OPW-1:0] OP_DIV = 4'd3;
  localparam logic [OPW-1:0] OP_MOD = 4'd4;
  localparam logic [OPW-1:0] OP_AND = 4'd5;
  localparam logic [OPW-1:0] OP_OR  = 4'd6;
  localparam logic [OPW-1:0] OP_XOR = 4'd7;
  localparam logic [OPW-1:0] OP_POW = 4'd8;

  // First set bit of valid[n-1:0] searching upward from ptr, wrapping at n.
  // Result is meaningless when no bit is set; callers qualify with |valid.
  function automatic logic [3:0] onehot_rr(input logic [MAXN-1:0] valid,
                                           input logic [3:0] ptr,
                                           input int n);
    logic [3:0] idx;
    logic       found;
    int         j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAXN; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && k < n && j < MAXN && valid[j[3:0]]) begin
        idx   = j[3:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/v2f_alu_core.sv
// Shared combinational datapath: one instance of each v2f binary op behind
// an opcode mux, with the zero-divisor, overflow, pow and illegal-op rules.
module v2f_alu_core
  import v2f_sched_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [OPW-1:0] i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [W-1:0]   o_y
);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  logic signed [W-1:0] w_sa;
  logic signed [W-1:0] w_sb;
  logic [W-1:0]        w_div;
  logic [W-1:0]        w_mod;
  logic [W-1:0]        w_pow;
  logic [W-1:0]        w_pow_base;
  logic [W-1:0]        w_pow_acc;

  assign w_sa = i_a;
  assign w_sb = i_b;

  // MIN / -1 overflows; the wrapped quotient is MIN itself and the remainder 0.
  always_comb begin
    w_div = '0;
    w_mod = '0;
    if (i_b == '0) begin
      w_div = '0;
      w_mod = '0;
    end else if (i_a == MIN_VAL && i_b == '1) begin
      w_div = MIN_VAL;
      w_mod = '0;
    end else begin
      w_div = w_sa / w_sb;
      w_mod = w_sa % w_sb;
    end
  end

  // Square-and-multiply over the non-sign exponent bits; everything wraps mod 2^W.
  always_comb begin
    w_pow_base = i_a;
    w_pow_acc  = ONE_VAL;
    for (int k = 0; k < W - 1; k++) begin
      if (i_b[k]) w_pow_acc = w_pow_acc * w_pow_base;
      w_pow_base = w_pow_base * w_pow_base;
    end
    w_pow = i_b[W-1] ? '0 : w_pow_acc;
  end

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_MUL:  o_y = i_a * i_b;
      OP_DIV:  o_y = w_div;
      OP_MOD:  o_y = w_mod;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_POW:  o_y = w_pow;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/v2f_alu_sched.sv
// Round-robin scheduler that time-shares one v2f ALU among N requesters and
// returns each result, tagged one-hot, after a fixed LATENCY.
module v2f_alu_sched
  import v2f_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [N-1:0]     req_valid,
  input  logic [OPW*N-1:0] req_op,
  input  logic [W*N-1:0]   req_a,
  input  logic [W*N-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     resp_valid,
  output logic [W-1:0]     resp_data,
  output logic             busy
);

  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] ONEHOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [OPW-1:0]  w_op_arr [N];
  logic [W-1:0]    w_a_arr  [N];
  logic [W-1:0]    w_b_arr  [N];
  logic [MAXN-1:0] w_valid_ext;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt;
  logic [IDW-1:0]  r_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_op_arr[gi] = req_op[gi*OPW +: OPW];
      assign w_a_arr[gi]  = req_a[gi*W +: W];
      assign w_b_arr[gi]  = req_b[gi*W +: W];
    end
  endgenerate

  always_comb begin
    w_valid_ext        = '0;
    w_valid_ext[N-1:0] = req_valid;
  end

  assign w_gnt_idx = IDW'(onehot_rr(w_valid_ext, 4'(r_ptr), N));
  // Grants are also blocked while reset is held so req_ready reads 0 then.
  assign w_gnt     = rst_n && !stall && (|req_valid);
  assign req_ready = w_gnt ? (ONEHOT0 << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt) begin
      r_ptr <= (w_gnt_idx == IDW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Stage 0: capture the granted operation.
  logic           r_s0_valid;
  logic [IDW-1:0] r_s0_tag;
  logic [OPW-1:0] r_s0_op;
  logic [W-1:0]   r_s0_a;
  logic [W-1:0]   r_s0_b;
  logic [W-1:0]   w_s0_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_tag   <= '0;
      r_s0_op    <= OP_ADD;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
    end else if (!stall) begin
      r_s0_valid <= w_gnt;
      if (w_gnt) begin
        r_s0_tag <= w_gnt_idx;
        r_s0_op  <= w_op_arr[w_gnt_idx];
        r_s0_a   <= w_a_arr[w_gnt_idx];
        r_s0_b   <= w_b_arr[w_gnt_idx];
      end
    end
  end

  v2f_alu_core #(.W(W)) u_core (
    .i_op (r_s0_op),
    .i_a  (r_s0_a),
    .i_b  (r_s0_b),
    .o_y  (w_s0_result)
  );

  logic           w_out_valid;
  logic [IDW-1:0] w_out_tag;
  logic [W-1:0]   w_out_data;
  logic           w_tail_busy;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_out_valid = r_s0_valid;
      assign w_out_tag   = r_s0_tag;
      assign w_out_data  = w_s0_result;
      assign w_tail_busy = 1'b0;
    end else begin : g_latn
      logic [LATENCY-1:1] r_pv;
      logic [IDW-1:0]     r_ptag  [1:LATENCY-1];
      logic [W-1:0]       r_pdata [1:LATENCY-1];

      // Payload only moves with a valid entry so the output data holds across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pv <= '0;
          for (int k = 1; k < LATENCY; k++) begin
            r_ptag[k]  <= '0;
            r_pdata[k] <= '0;
          end
        end else if (!stall) begin
          r_pv[1] <= r_s0_valid;
          if (r_s0_valid) begin
            r_ptag[1]  <= r_s0_tag;
            r_pdata[1] <= w_s0_result;
          end
          for (int k = 2; k < LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
            if (r_pv[k-1]) begin
              r_ptag[k]  <= r_ptag[k-1];
              r_pdata[k] <= r_pdata[k-1];
            end
          end
        end
      end

      assign w_out_valid = r_pv[LATENCY-1];
      assign w_out_tag   = r_ptag[LATENCY-1];
      assign w_out_data  = r_pdata[LATENCY-1];
      assign w_tail_busy = |r_pv;
    end
  endgenerate

  // A result parked on the output stage during stall is shown once stall drops.
  assign resp_valid = (w_out_valid && !stall) ? (ONEHOT0 << w_out_tag) : '0;
  assign resp_data  = w_out_data;
  assign busy       = r_s0_valid | w_tail_busy;

endmodule

// File: tb/tb_v2f_alu_sched.sv
// Randomized and directed scoreboard bench for v2f_alu_sched against a
// behavioural arbiter/ALU reference model.
module tb_v2f_alu_sched;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int LATENCY = 2;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic           clk;
  logic           rst_n;
  logic           stall;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           busy;

  v2f_alu_sched #(.N(N), .W(W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          g;
    int          snap;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          m_ptr = 0;
  int          total_stalls = 0;
  logic        use_exp = 1'b0;
  logic [31:0] exp_val = '0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      r;
    logic [31:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    case (op)
      4'd0: r = sa + sb;
      4'd1: r = sa - sb;
      4'd2: r = sa * sb;
      4'd3: r = (sb == 0) ? 0 : sa / sb;
      4'd4: r = (sb == 0) ? 0 : sa % sb;
      4'd5: r = longint'(a & b);
      4'd6: r = longint'(a | b);
      4'd7: r = longint'(a ^ b);
      4'd8: begin
        p = 32'd1;
        if (sb < 0) p = 32'd0;
        else for (longint k = 0; k < sb; k++) p = p * a;
        r = longint'(p);
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic set_one(input int idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_op[idx*4 +: 4] = op;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic rand_operands();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < N; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      case ($urandom_range(0, 2))
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 40)) - 32'd20;
        default: a = MINV;
      endcase
      case ($urandom_range(0, 2))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 8)) - 32'd4;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd0;
      endcase
      if (op == 4'd8) b = 32'($urandom_range(0, 43)) - 32'd3;
      req_op[i*4 +: 4] = op;
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
    end
  endtask

  // Called at posedge+1: checks this cycle's grant, records it, advances one cycle.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           gidx;
    logic         found;
    exp_t         e;
    #1;
    exp_rdy = '0;
    found   = 1'b0;
    gidx    = 0;
    if (rst_n && !stall) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          gidx  = j;
        end
      end
    end
    if (found) exp_rdy[gidx] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL grant cyc=%0d req_ready=%b expected=%b", cyc, req_ready, exp_rdy);
    end
    if (found) begin
      e.tag  = gidx;
      e.data = use_exp ? exp_val : ref_alu(req_op[gidx*4 +: 4], req_a[gidx*32 +: 32],
                                           req_b[gidx*32 +: 32]);
      e.g    = cyc;
      e.snap = total_stalls;
      q.push_back(e);
      m_ptr = (gidx + 1) % N;
      $display("issue cyc=%0d req=%0d op=%0d a=%0d b=%0d exp=%0d", cyc, gidx,
               req_op[gidx*4 +: 4], $signed(req_a[gidx*32 +: 32]),
               $signed(req_b[gidx*32 +: 32]), $signed(e.data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input int idx, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
    set_one(idx, op, a, b);
    use_exp = 1'b1;
    exp_val = expv;
    step();
    use_exp   = 1'b0;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    stall     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every cycle compare busy and any presented result with the scoreboard.
  initial begin
    exp_t        e;
    logic        exp_busy;
    logic [N-1:0] exp_onehot;
    int          due;
    forever begin
      @(negedge clk);
      exp_busy = 1'b0;
      foreach (q[i]) if (q[i].g < cyc) exp_busy = 1'b1;
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, exp_busy);
      end
      if (resp_valid !== '0) begin
        if (stall) begin
          failures++;
          $display("FAIL resp_during_stall cyc=%0d resp_valid=%b expected=0", cyc, resp_valid);
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp cyc=%0d resp_valid=%b expected=0", cyc, resp_valid);
        end else begin
          e = q.pop_front();
          exp_onehot = '0;
          exp_onehot[e.tag] = 1'b1;
          due = e.g + LATENCY + (total_stalls - e.snap);
          checks++;
          if (resp_valid !== exp_onehot || resp_data !== e.data || cyc != due) begin
            failures++;
            $display("FAIL resp cyc=%0d got valid=%b data=%0d expected valid=%b data=%0d cyc=%0d",
                     cyc, resp_valid, $signed(resp_data), exp_onehot, $signed(e.data), due);
          end else begin
            $display("resp cyc=%0d req=%0d data=%0d", cyc, e.tag, $signed(resp_data));
          end
        end
      end
      if (stall) total_stalls++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    req_valid = '1;
    req_op    = '0;
    req_a     = '1;
    req_b     = '1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (req_ready !== '0)  begin failures++; $display("FAIL reset_ready got=%b expected=0", req_ready); end
    if (resp_valid !== '0) begin failures++; $display("FAIL reset_resp got=%b expected=0", resp_valid); end
    if (resp_data !== '0)  begin failures++; $display("FAIL reset_data got=%0h expected=0", resp_data); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    req_valid = '0;
    rst_n     = 1'b1;
    idle(2);

    // Reset while an op is in flight: it must vanish and ptr must return to 0.
    directed(1, 4'd0, 32'd5, 32'd7, 32'd12);
    rst_n = 1'b0;
    q.delete();
    m_ptr = 0;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Fairness: all requesters active for 8 cycles from ptr 0.
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_operands();
      step();
    end
    idle(3);

    // Basic latency.
    directed(2, 4'd2, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    idle(3);

    // Edge arithmetic.
    directed(0, 4'd3, 32'd7, 32'd0, 32'd0);
    directed(0, 4'd4, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF);
    directed(0, 4'd3, MINV, 32'hFFFF_FFFF, MINV);
    directed(0, 4'd8, 32'd2, 32'd31, MINV);
    directed(0, 4'd8, 32'd2, 32'hFFFF_FFFF, 32'd0);
    directed(0, 4'd12, 32'd5, 32'd6, 32'd0);
    directed(1, 4'd8, 32'd0, 32'd0, 32'd1);
    idle(3);

    // Stall: no grants while stalled, result delayed by the stall length.
    rand_operands();
    set_one(3, 4'd0, 32'd100, 32'd23);
    step();
    stall     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 3; i++) step();
    stall     = 1'b0;
    req_valid = '0;
    step();
    req_valid = '1;
    step();
    idle(4);

    // Sparse wrap: bring ptr to 3, then only req 1, then reqs 0 and 2.
    directed(2, 4'd6, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0);
    directed(1, 4'd1, 32'd3, 32'd10, 32'hFFFF_FFF9);
    set_one(0, 4'd7, 32'hFF, 32'h0F);
    req_valid = 4'b0101;
    req_op[8 +: 4] = 4'd5;
    req_a[64 +: 32] = 32'hF0F0;
    req_b[64 +: 32] = 32'h0FF0;
    use_exp = 1'b1;
    exp_val = 32'h00F0;
    step();
    use_exp = 1'b0;
    idle(4);

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      rand_operands();
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      stall     = ($urandom_range(0, 7) == 0);
      step();
    end
    idle(10);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
